// File: rtl/mem_stall_controller.sv
// mem_stall_controller
// Pipeline stall controller for data-cache misses. A miss in the MEM stage
// freezes the pipeline and issues a request to backing memory. The pipeline
// stays frozen until the refill completes or a timeout expires, and then
// advances for one resume cycle.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no miss outstanding; pipeline advances unless a miss is seen
// REQ    | request presented to backing memory, waiting for grant
// WAIT   | request granted, waiting for mem_done or timeout
// RESUME | refill finished (or abandoned); pipeline advances one cycle
//
// Optional feature: define STALL_COUNTER_EN to add the saturating
// stall_cycles counter and its output port.

module mem_stall_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             cache_hit,
    input  logic             branch_taken,
    input  logic             mem_gnt,
    input  logic             mem_done,
    output logic             pipe_en,
    output logic             flush,
    output logic             mem_req,
    output logic             mem_we,
    output logic             busy,
    output logic             err
`ifdef STALL_COUNTER_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        RESUME = 2'd3
    } state_t;

    // Last WAIT-cycle count value; reaching it without mem_done ends the wait.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       miss;

    assign miss = (mem_read | mem_write) & ~cache_hit;
    assign busy = (state != IDLE);

    // FSM with registered memory-request outputs. The mem_we register is the
    // write flag captured on entry to REQ, so it holds steady while REQ waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        mem_we  <= mem_write;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= 8'd0;
                        state    <= mem_done ? RESUME : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        state <= RESUME;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= RESUME;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESUME: begin
                    wait_cnt <= 8'd0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pipeline enable: combinational on a miss in IDLE so the offending access
    // is held in the same cycle; forced low while reset is asserted.
    always_comb begin
        pipe_en = 1'b0;
        case (state)
            IDLE:    pipe_en = ~miss;
            RESUME:  pipe_en = 1'b1;
            default: pipe_en = 1'b0;
        endcase
        pipe_en = pipe_en & rst_n;
    end

    // A taken branch only squashes when the pipeline actually advances.
    always_comb begin
        flush = branch_taken & pipe_en;
    end

`ifdef STALL_COUNTER_EN
    // Saturating count of stalled cycles since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pipe_en && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stall_controller.sv
// tb_mem_stall_controller
// Cycle table of inputs and hand-derived expected outputs, pushed through a
// scoreboard queue, followed by asynchronous-reset sequences in REQ and WAIT.
// Built with TIMEOUT_CYCLES=4 so timeout behaviour is reachable quickly.

module tb_mem_stall_controller;

    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    logic mem_read, mem_write, cache_hit, branch_taken, mem_gnt, mem_done;
    logic pipe_en, flush, mem_req, mem_we, busy, err;
`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    mem_stall_controller #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .cache_hit   (cache_hit),
        .branch_taken(branch_taken),
        .mem_gnt     (mem_gnt),
        .mem_done    (mem_done),
        .pipe_en     (pipe_en),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .busy        (busy),
        .err         (err)
`ifdef STALL_COUNTER_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        bit    rd, wr, hit, br, gnt, done;
        bit    pe, fl, rq, we, bz, er;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(string tag,
                                bit rd, bit wr, bit hit, bit br, bit gnt, bit done,
                                bit pe, bit fl, bit rq, bit we, bit bz, bit er);
        vec_t v;
        v.tag = tag;
        v.rd = rd; v.wr = wr; v.hit = hit; v.br = br; v.gnt = gnt; v.done = done;
        v.pe = pe; v.fl = fl; v.rq = rq; v.we = we; v.bz = bz; v.er = er;
        return v;
    endfunction

    task automatic check(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        mem_read     = v.rd;
        mem_write    = v.wr;
        cache_hit    = v.hit;
        branch_taken = v.br;
        mem_gnt      = v.gnt;
        mem_done     = v.done;
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; cache_hit = 0;
        branch_taken = 0; mem_gnt = 0; mem_done = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   st_stall  = 0;
        int   st_req    = 0;
        int   exp_stall = 0;

        //                 tag               rd wr hi br gn dn   pe fl rq we bz er
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("hit",          1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("hit_br",           1, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("idle_gnt_done",    0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0));
        // store miss: grant on 2nd REQ cycle, done on 4th WAIT cycle (same
        // cycle as the timeout would fire, so err must stay 0)
        tbl.push_back(mk("st_miss",          0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("st_req_nognt",     0, 1, 0, 0, 0, 1,   0, 0, 1, 1, 1, 0));
        tbl.push_back(mk("st_req_gnt",       0, 1, 0, 0, 1, 0,   0, 0, 1, 1, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("st_wait",      0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("st_wait_done",     0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("st_resume",        0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("st_idle",          0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        // load miss with grant and done together: pipe_en 0,0,1
        tbl.push_back(mk("ld_miss",          1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ld_req",           1, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1, 0));
        tbl.push_back(mk("ld_resume",        1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("ld_idle",          0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        // branch held through a stall is deferred to the resume cycle
        tbl.push_back(mk("br_miss",          1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("br_req",           1, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1, 0));
        tbl.push_back(mk("br_wait_done",     1, 0, 0, 1, 1, 1,   0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("br_resume",        1, 0, 0, 1, 0, 0,   1, 1, 0, 0, 1, 0));
        tbl.push_back(mk("br_idle",          0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        // timeout after 4 WAIT cycles, err sticky, next miss still serviced
        tbl.push_back(mk("to_miss",          1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("to_req",           1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("to_wait",      1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("to_resume",        1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1));
        tbl.push_back(mk("to_idle_done",     0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("re_miss",          0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("re_req",           0, 1, 0, 0, 1, 1,   0, 0, 1, 1, 1, 1));
        tbl.push_back(mk("re_resume",        0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1));
        tbl.push_back(mk("re_idle",          0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1));

        // reset held with a hit and a taken branch on the inputs
        rst_n = 1'b0;
        mem_read = 1; mem_write = 0; cache_hit = 1;
        branch_taken = 1; mem_gnt = 0; mem_done = 0;
        @(negedge clk);
        check("rst_pipe_en", pipe_en, 1'b0);
        check("rst_flush",   flush,   1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we",  mem_we,  1'b0);
        check("rst_busy",    busy,    1'b0);
        check("rst_err",     err,     1'b0);
`ifdef STALL_COUNTER_EN
        check_int("rst_stall_cycles", int'(stall_cycles), 0);
`endif
        idle_inputs();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            check({e.tag, ".pipe_en"}, pipe_en, e.pe);
            check({e.tag, ".flush"},   flush,   e.fl);
            check({e.tag, ".mem_req"}, mem_req, e.rq);
            check({e.tag, ".mem_we"},  mem_we,  e.we);
            check({e.tag, ".busy"},    busy,    e.bz);
            check({e.tag, ".err"},     err,     e.er);
`ifdef STALL_COUNTER_EN
            check_int({e.tag, ".stall_cycles"}, int'(stall_cycles), exp_stall);
`endif
            if (!e.pe) exp_stall++;
            if (e.tag.substr(0, 2) == "st_") begin
                if (!pipe_en) st_stall++;
                if (mem_req)  st_req++;
            end
        end
        check_int("store_stall_len", st_stall, 7);
        check_int("store_req_len",   st_req,   2);

        // asynchronous reset while in WAIT (err is already set from the timeout)
        @(posedge clk); #1; idle_inputs(); mem_read = 1;
        @(posedge clk); #1; mem_gnt = 1;
        @(posedge clk); #1; mem_gnt = 0;
        @(negedge clk);
        check("wait_pre_busy", busy, 1'b1);
        check("wait_pre_err",  err,  1'b1);
        #1;
        branch_taken = 1;
        rst_n = 1'b0;
        #1;
        check("wait_rst_busy",    busy,    1'b0);
        check("wait_rst_mem_req", mem_req, 1'b0);
        check("wait_rst_err",     err,     1'b0);
        check("wait_rst_pipe_en", pipe_en, 1'b0);
        check("wait_rst_flush",   flush,   1'b0);
`ifdef STALL_COUNTER_EN
        check_int("wait_rst_stall_cycles", int'(stall_cycles), 0);
`endif
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // asynchronous reset while a store request is outstanding in REQ
        @(posedge clk); #1; mem_write = 1; cache_hit = 0;
        @(posedge clk); #2;
        check("req_pre_mem_req", mem_req, 1'b1);
        check("req_pre_mem_we",  mem_we,  1'b1);
        rst_n = 1'b0;
        #1;
        check("req_rst_mem_req", mem_req, 1'b0);
        check("req_rst_mem_we",  mem_we,  1'b0);
        check("req_rst_busy",    busy,    1'b0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // after release the controller is idle and a hit advances at once
        @(posedge clk); #1; mem_read = 1; cache_hit = 1;
        @(negedge clk);
        check("post_rst_pipe_en", pipe_en, 1'b1);
        check("post_rst_busy",    busy,    1'b0);
        check("post_rst_mem_req", mem_req, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stall_controller.md
MEM_STALL_CONTROLLER -- requirements
Module: mem_stall_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT-state cycles before a refill is abandoned; range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_read  input  1  MEM-stage load in progress.
REQ-006 mem_write  input  1  MEM-stage store in progress.
REQ-007 cache_hit  input  1  data cache hit for the current MEM-stage access.
REQ-008 branch_taken  input  1  resolved branch (branch control AND zero) in MEM stage.
REQ-009 mem_gnt  input  1  backing memory accepts the request.
REQ-010 mem_done  input  1  backing memory refill/write complete, one-cycle pulse.
REQ-011 pipe_en  output  1  enable for all pipeline registers (drives their hit input); 1 = advance.
REQ-012 flush  output  1  squash younger stages.
REQ-013 mem_req  output  1  request to backing memory.
REQ-014 mem_we  output  1  request is a write.
REQ-015 busy  output  1  miss being serviced (state != IDLE).
REQ-016 err  output  1  sticky refill-timeout flag.
REQ-017 stall_cycles  output  CNT_W  saturating count of cycles with pipe_en=0 (present only under STALL_COUNTER_EN).

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, RESUME, encoded in registered state.
REQ-019 IDLE: access = mem_read|mem_write; if access & !cache_hit, pipe_en SHALL be 0 in that same cycle (combinational) and next state REQ; else pipe_en=1, stay IDLE.
REQ-020 On IDLE->REQ, the controller SHALL latch mem_write into an internal we flag.
REQ-021 REQ: mem_req=1, mem_we=latched flag, pipe_en=0; held until mem_gnt=1; with mem_gnt & mem_done same cycle go RESUME, with mem_gnt only go WAIT.
REQ-022 WAIT: mem_req=0, pipe_en=0, wait counter increments each cycle; mem_done=1 -> RESUME; counter reaching TIMEOUT_CYCLES without mem_done -> set err, go RESUME.
REQ-023 mem_done and timeout in the same cycle: mem_done SHALL win, err unchanged.
REQ-024 RESUME: pipe_en=1 for exactly one cycle, wait counter cleared, next state IDLE regardless of inputs.
REQ-025 flush SHALL equal branch_taken AND pipe_en; a branch during a stall is therefore deferred until the pipeline advances.
REQ-026 mem_gnt/mem_done outside REQ/WAIT SHALL be ignored.
REQ-027 mem_req and mem_we SHALL be 0 in IDLE, WAIT and RESUME.
REQ-028 err SHALL remain 1 once set until reset.
REQ-029 Miss-detection to first pipe_en=1 latency: 3 cycles minimum (IDLE miss, REQ with gnt+done, RESUME).

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, wait counter 0, we flag 0, err 0, stall_cycles 0, mem_req 0, mem_we 0.
REQ-031 During reset pipe_en SHALL be 0 and flush 0; after release pipe_en follows REQ-019.
REQ-032 Reset asserted mid-refill SHALL abandon the request without waiting for mem_done.

Configuration
REQ-033 Macro STALL_COUNTER_EN: when defined, stall_cycles port and counter exist, incrementing each cycle with pipe_en=0 out of reset, saturating at all-ones; when undefined, port and counter are absent and all other behaviour is identical.

Verification
REQ-034 Load with cache_hit=1 for 4 cycles -> pipe_en=1 throughout, mem_req never asserted, busy=0.
REQ-035 Store miss, mem_gnt after 2 REQ cycles, mem_done 3 cycles later -> mem_req=1, mem_we=1 for 2 cycles, pipe_en=0 for 7 cycles, then RESUME pipe_en=1 one cycle, IDLE.
REQ-036 Load miss with mem_gnt and mem_done in same REQ cycle -> pipe_en 0,0,1 (IDLE, REQ, RESUME), mem_we=0.
REQ-037 TIMEOUT_CYCLES=4, mem_done never asserted -> err=1 after 4 WAIT cycles, RESUME pipe_en=1, err stays 1; next miss still serviced.
REQ-038 branch_taken held during a stall -> flush=0 while pipe_en=0, flush=1 in RESUME cycle.
REQ-039 rst_n low in WAIT -> state IDLE, mem_req=0, err=0, stall_cycles=0 (with STALL_COUNTER_EN) without clock edge.
